mul_unit: RTL

//  Iterative multiplier that executes the MUL/UMULL/SMULL operations issued by the multicycle control FSM.
//  The controller selects the operation through ALUControl and pulses start with SrcA/SrcB.
//  It then waits on done and writes the 32- or 64-bit product back (RegSrc64b selects the long writeback).

---
 rtl/mul_unit_pkg.sv | 24 ++
 rtl/mul_unit_negate64.sv | 17 +
 rtl/mul_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mul_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_unit_pkg
// Brief    : Op codes shared with decode, and state encoding for the multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package mul_unit_pkg;

    localparam logic [2:0] c_MUL_OP   = 3'b100;
    localparam logic [2:0] c_UMULL_OP = 3'b101;
    localparam logic [2:0] c_SMULL_OP = 3'b110;

    localparam int         c_STATE_W  = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_RUN  = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_FIX  = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DONE = 2'd3;

    function automatic logic op_valid(input logic [2:0] op);
        return (op == c_MUL_OP) || (op == c_UMULL_OP) || (op == c_SMULL_OP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_unit_negate64.sv
`default_nettype none
// ============================================================================
// Module   : mul_unit_negate64
// Brief    : Combinational two's-complement negate, N bits wide.
// Revision : 1.0 - initial release
// ============================================================================
module mul_unit_negate64 #(
    parameter int N = 64
) (
    input  logic [N-1:0] i_a,
    output logic [N-1:0] o_y
);

    assign o_y = ~i_a + {{(N-1){1'b0}}, 1'b1};

endmodule
`default_nettype wire

// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_unit
// Brief    : Iterative shift-add multiplier for MUL / UMULL / SMULL.
// Revision : 1.0 - initial release
// ============================================================================
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int                c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_hi;
    logic                 r_n;
    logic                 r_z;
    logic                 r_done;

    logic [WIDTH-1:0]     w_a_neg;
    logic [WIDTH-1:0]     w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_signed;
    logic                 w_accept;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_acc_neg;
    logic [2*WIDTH-1:0]   w_prod;

    mul_unit_negate64 #(.N(WIDTH)) u_neg_a (
        .i_a (a),
        .o_y (w_a_neg)
    );

    mul_unit_negate64 #(.N(WIDTH)) u_neg_b (
        .i_a (b),
        .o_y (w_b_neg)
    );

    mul_unit_negate64 #(.N(2*WIDTH)) u_neg_acc (
        .i_a (r_acc),
        .o_y (w_acc_neg)
    );

    assign w_signed = (op == c_SMULL_OP);
    assign w_a_mag  = (w_signed && a[WIDTH-1]) ? w_a_neg : a;
    assign w_b_mag  = (w_signed && b[WIDTH-1]) ? w_b_neg : b;
    assign w_accept = start && op_valid(op) &&
                      ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));

    // Add into the upper half, then shift the whole {carry, acc} right by one.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                        {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg ? w_acc_neg : r_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_op     <= 3'b000;
            r_lo     <= '0;
            r_hi     <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_accept) begin
                        r_state  <= c_ST_RUN;
                        r_op     <= op;
                        r_neg    <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_count  <= c_CNT_LAST;
                        r_acc    <= '0;
                    end else begin
                        r_state  <= c_ST_IDLE;
                    end
                end
                c_ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    if (r_count == '0) begin
                        r_state <= c_ST_FIX;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                c_ST_FIX: begin
                    r_state <= c_ST_DONE;
                    r_done  <= 1'b1;
                    r_lo    <= w_prod[WIDTH-1:0];
                    if (r_op == c_MUL_OP) begin
                        r_hi <= '0;
                        r_n  <= w_prod[WIDTH-1];
                        r_z  <= (w_prod[WIDTH-1:0] == '0);
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_n  <= w_prod[2*WIDTH-1];
                        r_z  <= (w_prod == '0);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == c_ST_RUN) || (r_state == c_ST_FIX);
    assign done      = r_done;
    assign result_lo = r_lo;
    assign result_hi = r_hi;
    assign flag_n    = r_n;
    assign flag_z    = r_z;

endmodule
`default_nettype wire
